// File: rtl/hack_pkg.sv
// hack_pkg: shared types and constants for the Hack run controller
package hack_pkg;
  localparam int DATA_W = 16;
  localparam int PC_W = 15;
  localparam logic [DATA_W-1:0] HALT_JMP = 16'hEA87;
  typedef enum logic [2:0] {IDLE, LOAD, BOOT, RUN, HALT, FAULT} state_e;
endpackage

// File: rtl/hack_rom.sv
// hack_rom: instruction store, one synchronous write port and one asynchronous read port
module hack_rom #(
  parameter int DATA_W = 16,
  parameter int AW = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**AW];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/hack_run_ctrl.sv
// hack_run_ctrl: load/boot/run sequencer for the Hack CPU with loop-halt detection and watchdog
// HACK_RUN_STEP_EN adds step_mode/step ports that gate cpu_en one cycle per step in RUN
module hack_run_ctrl #(
  parameter int DATA_W = hack_pkg::DATA_W,
  parameter int PC_W = hack_pkg::PC_W,
  parameter int ROM_AW = 8,
  parameter int HALT_REP = 4,
  parameter int WDOG_MAX = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef HACK_RUN_STEP_EN
  input  logic              step_mode,
  input  logic              step,
`endif
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic [PC_W-1:0]   cpu_pc,
  output logic [DATA_W-1:0] cpu_instr,
  output logic              cpu_rst,
  output logic              cpu_en,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              fault,
  output logic [ROM_AW:0]   prog_len,
  output logic [31:0]       cycle_cnt
);
  import hack_pkg::*;
  localparam logic [ROM_AW:0] DEPTH = {1'b1, {ROM_AW{1'b0}}};
  localparam int HW = $clog2(HALT_REP + 1);
  state_e state_q, state_d;
  logic [ROM_AW:0] prog_len_q, prog_len_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [PC_W-1:0] pc_d1_q, pc_d1_d, pc_d2_q, pc_d2_d;
  logic [1:0] hist_q, hist_d;
  logic [HW-1:0] hit_cnt_q, hit_cnt_d;
  logic done_q, done_d, timeout_q, timeout_d, fault_q, fault_d;
  logic en, hit, rom_we;
  logic [DATA_W-1:0] rom_rdata;
`ifdef HACK_RUN_STEP_EN
  assign en = state_q == RUN && (!step_mode || step);
`else
  assign en = state_q == RUN;
`endif
  // hist_q counts enabled RUN cycles up to 2 so pc_d2_q is meaningful before comparing
  assign hit = hist_q == 2'd2 && cpu_pc == pc_d2_q;
  always_comb begin
    state_d = state_q;
    prog_len_d = prog_len_q;
    cycle_cnt_d = cycle_cnt_q;
    pc_d1_d = pc_d1_q;
    pc_d2_d = pc_d2_q;
    hist_d = hist_q;
    hit_cnt_d = hit_cnt_q;
    done_d = done_q;
    timeout_d = timeout_q;
    fault_d = fault_q;
    rom_we = 1'b0;
    case (state_q)
      IDLE, HALT, FAULT: if (start) begin
        state_d = LOAD;
        prog_len_d = '0;
        cycle_cnt_d = '0;
        done_d = 1'b0;
        timeout_d = 1'b0;
        fault_d = 1'b0;
      end
      LOAD: if (ld_valid) begin
        if (prog_len_q == DEPTH) begin
          fault_d = 1'b1;
          state_d = FAULT;
        end else begin
          rom_we = 1'b1;
          prog_len_d = prog_len_q + (ROM_AW+1)'(1);
          state_d = ld_last ? BOOT : LOAD;
        end
      end
      BOOT: begin
        state_d = RUN;
        hist_d = '0;
        hit_cnt_d = '0;
      end
      RUN: if (en) begin
        cycle_cnt_d = cycle_cnt_q + 32'(~&cycle_cnt_q);
        pc_d1_d = cpu_pc;
        pc_d2_d = pc_d1_q;
        hist_d = hist_q + 2'(hist_q != 2'd2);
        hit_cnt_d = hit ? hit_cnt_q + HW'(1) : '0;
        done_d = hit_cnt_d == HW'(HALT_REP);
        timeout_d = cycle_cnt_d == 32'(WDOG_MAX);
        state_d = (done_d || timeout_d) ? HALT : RUN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      prog_len_q <= '0;
      cycle_cnt_q <= '0;
      pc_d1_q <= '0;
      pc_d2_q <= '0;
      hist_q <= '0;
      hit_cnt_q <= '0;
      done_q <= 1'b0;
      timeout_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prog_len_q <= prog_len_d;
      cycle_cnt_q <= cycle_cnt_d;
      pc_d1_q <= pc_d1_d;
      pc_d2_q <= pc_d2_d;
      hist_q <= hist_d;
      hit_cnt_q <= hit_cnt_d;
      done_q <= done_d;
      timeout_q <= timeout_d;
      fault_q <= fault_d;
    end
  hack_rom #(.DATA_W(DATA_W), .AW(ROM_AW)) u_rom (
    .clk   (clk),
    .we    (rom_we),
    .waddr (prog_len_q[ROM_AW-1:0]),
    .wdata (ld_data),
    .raddr (cpu_pc[ROM_AW-1:0]),
    .rdata (rom_rdata)
  );
  assign cpu_instr = cpu_pc[PC_W-1:ROM_AW] == '0 ? rom_rdata : '0;
  assign ld_ready = state_q == LOAD;
  assign cpu_rst = !(state_q == RUN || state_q == HALT);
  assign cpu_en = en;
  assign busy = state_q == LOAD || state_q == BOOT || state_q == RUN;
  assign done = done_q;
  assign timeout = timeout_q;
  assign fault = fault_q;
  assign prog_len = prog_len_q;
  assign cycle_cnt = cycle_cnt_q;
endmodule
